// File: rtl/cpu_pkg.sv
// Shared CPU datapath definitions: immediate expansion modes and default widths.
package cpu_pkg;

    localparam int unsigned DATA_W_DEFAULT = 32;
    localparam int unsigned IMM_W_DEFAULT  = 16;

    typedef enum logic [1:0] {
        IMM_REG   = 2'd0,
        IMM_SEXT  = 2'd1,
        IMM_ZEXT  = 2'd2,
        IMM_UPPER = 2'd3
    } imm_mode_e;

endpackage

// File: rtl/imm_expand.sv
// Combinational immediate expansion to datapath width; shared by operand and branch-target paths.
module imm_expand
    import cpu_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEFAULT,
    parameter int unsigned IMM_W  = IMM_W_DEFAULT
) (
    input  logic [IMM_W-1:0]  imm,
    input  imm_mode_e         imm_mode,
    output logic [DATA_W-1:0] ext
);

    localparam int unsigned PAD_W = DATA_W - IMM_W;

    always_comb begin
        ext = '0;
        case (imm_mode)
            IMM_SEXT:  ext = {{PAD_W{imm[IMM_W-1]}}, imm};
            IMM_ZEXT:  ext = {{PAD_W{1'b0}}, imm};
            IMM_UPPER: ext = {imm, {PAD_W{1'b0}}};
            default:   ext = '0;
        endcase
    end

endmodule

// File: rtl/alu_operand_b_stage.sv
// EX-stage operand-B select (register, forwarding or expanded immediate) held in a
// one-deep valid/ready slot with flush and a sticky out-of-range select flag.
module alu_operand_b_stage
    import cpu_pkg::*;
#(
    parameter  int unsigned DATA_W  = DATA_W_DEFAULT,
    parameter  int unsigned IMM_W   = IMM_W_DEFAULT,
    parameter  int unsigned NUM_FWD = 3,
    localparam int unsigned SEL_W   = $clog2(NUM_FWD + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_W-1:0]         qb,
    input  logic [SEL_W-1:0]          fwd_sel,
    input  logic [NUM_FWD*DATA_W-1:0] fwd_data,
    input  logic [IMM_W-1:0]          imm,
    input  logic [1:0]                imm_mode,
    input  logic                      flush,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_W-1:0]         b_out,
    output logic                      sel_err
);

    imm_mode_e         mode;
    logic [DATA_W-1:0] imm_ext;
    logic [DATA_W-1:0] fwd_val;
    logic              fwd_bad;
    logic [DATA_W-1:0] src;
    logic              accept;

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] b_q,     b_d;
    logic              err_q,   err_d;

    assign mode = imm_mode_e'(imm_mode);

    imm_expand #(
        .DATA_W (DATA_W),
        .IMM_W  (IMM_W)
    ) u_imm_expand (
        .imm      (imm),
        .imm_mode (mode),
        .ext      (imm_ext)
    );

    // Out-of-range selects fall back to the register-file value.
    always_comb begin
        fwd_val = qb;
        for (int unsigned k = 1; k <= NUM_FWD; k++) begin
            if (fwd_sel == SEL_W'(k)) begin
                fwd_val = fwd_data[k*DATA_W-1 -: DATA_W];
            end
        end
        fwd_bad = (32'(fwd_sel) > NUM_FWD);
    end

    assign src      = (mode == IMM_REG) ? fwd_val : imm_ext;
    assign in_ready = !valid_q || out_ready;
    assign accept   = in_valid && in_ready && !flush;

    always_comb begin
        valid_d = valid_q;
        b_d     = b_q;
        err_d   = err_q | (accept && (mode == IMM_REG) && fwd_bad);
        if (flush) begin
            valid_d = 1'b0;
        end else if (accept) begin
            valid_d = 1'b1;
            b_d     = src;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            b_q     <= '0;
            err_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            b_q     <= b_d;
            err_q   <= err_d;
        end
    end

    assign out_valid = valid_q;
    assign b_out     = b_q;
    assign sel_err   = err_q;

endmodule

// File: tb/tb_alu_operand_b_stage.sv
// Bench for alu_operand_b_stage: directed scenarios plus a random run against a
// behavioural model, on a 3-source and a 2-source instance sharing the same inputs.
module tb_alu_operand_b_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] qb = '0;
    logic [1:0]  fwd_sel = '0;
    logic [95:0] fwd_data = '0;
    logic [15:0] imm = '0;
    logic [1:0]  imm_mode = '0;
    logic        flush = 1'b0;
    logic        out_ready = 1'b1;

    logic        in_ready_a, out_valid_a, sel_err_a;
    logic [31:0] b_out_a;
    logic        in_ready_b, out_valid_b, sel_err_b;
    logic [31:0] b_out_b;

    int n_cmp = 0;
    int n_bad = 0;

    // Model state per instance: index 0 has 3 sources, index 1 has 2.
    logic        m_valid [2];
    logic [31:0] m_b     [2];
    logic        m_err   [2];

    always #5 clk = ~clk;

    alu_operand_b_stage #(.DATA_W(32), .IMM_W(16), .NUM_FWD(3)) u_dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a),
        .qb(qb), .fwd_sel(fwd_sel), .fwd_data(fwd_data), .imm(imm),
        .imm_mode(imm_mode), .flush(flush), .out_valid(out_valid_a),
        .out_ready(out_ready), .b_out(b_out_a), .sel_err(sel_err_a)
    );

    alu_operand_b_stage #(.DATA_W(32), .IMM_W(16), .NUM_FWD(2)) u_dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b),
        .qb(qb), .fwd_sel(fwd_sel), .fwd_data(fwd_data[63:0]), .imm(imm),
        .imm_mode(imm_mode), .flush(flush), .out_valid(out_valid_b),
        .out_ready(out_ready), .b_out(b_out_b), .sel_err(sel_err_b)
    );

    function automatic logic [31:0] ref_src(int unsigned nf);
        int unsigned s;
        s = int'(fwd_sel);
        case (imm_mode)
            2'd1:    return {{16{imm[15]}}, imm};
            2'd2:    return {16'h0000, imm};
            2'd3:    return {imm, 16'h0000};
            default: begin
                if (s == 0 || s > nf) return qb;
                return fwd_data[(s-1)*32 +: 32];
            end
        endcase
    endfunction

    // Advance one clock, updating the model from the inputs present before the edge.
    task automatic tick();
        logic        nv [2];
        logic [31:0] nb [2];
        logic        ne [2];
        logic        acc;
        for (int i = 0; i < 2; i++) begin
            nv[i] = m_valid[i];
            nb[i] = m_b[i];
            ne[i] = m_err[i];
            if (rst) begin
                nv[i] = 1'b0;
                nb[i] = '0;
                ne[i] = 1'b0;
            end else begin
                acc = in_valid && (!m_valid[i] || out_ready) && !flush;
                if (acc && imm_mode == 2'd0 && int'(fwd_sel) > (i == 0 ? 3 : 2)) ne[i] = 1'b1;
                if (flush) nv[i] = 1'b0;
                else if (acc) begin
                    nv[i] = 1'b1;
                    nb[i] = ref_src(i == 0 ? 3 : 2);
                end else if (out_ready) nv[i] = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            m_valid[i] = nv[i];
            m_b[i]     = nb[i];
            m_err[i]   = ne[i];
        end
    endtask

    task automatic quiet();
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        fwd_sel   = '0;
        imm_mode  = 2'd0;
    endtask

    task automatic test_reset();
        quiet();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        n_cmp++; if (out_valid_a !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", out_valid_a); end
        n_cmp++; if (b_out_a !== 32'h0) begin n_bad++; $display("FAIL reset_b: got %h want 0", b_out_a); end
        n_cmp++; if (sel_err_a !== 1'b0 || sel_err_b !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b/%b want 0/0", sel_err_a, sel_err_b); end
        tick();
        n_cmp++; if (in_ready_a !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready_a); end
        out_ready = 1'b0;
        #1;
        n_cmp++; if (in_ready_a !== 1'b1) begin n_bad++; $display("FAIL idle_in_ready_no_oready: got %b want 1", in_ready_a); end
        out_ready = 1'b1;
    endtask

    task automatic test_imm_modes();
        logic [1:0]  modes [4] = '{2'd1, 2'd2, 2'd3, 2'd1};
        logic [1:0]  sels  [4] = '{2'd0, 2'd0, 2'd0, 2'd2};
        logic [31:0] exps  [4] = '{32'hFFFF8001, 32'h00008001, 32'h80010000, 32'hFFFF8001};
        quiet();
        imm = 16'h8001;
        qb  = 32'h1234_5678;
        fwd_data = {32'hC0, 32'hB0, 32'hA0};
        for (int i = 0; i < 4; i++) begin
            imm_mode = modes[i];
            fwd_sel  = sels[i];
            in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            n_cmp++; if (out_valid_a !== 1'b1 || b_out_a !== exps[i]) begin n_bad++; $display("FAIL imm_mode%0d: got v=%b %h want v=1 %h", i, out_valid_a, b_out_a, exps[i]); end
            n_cmp++; if (b_out_b !== exps[i] || sel_err_b !== 1'b0) begin n_bad++; $display("FAIL imm_mode%0d_b: got %h err=%b want %h err=0", i, b_out_b, sel_err_b, exps[i]); end
            tick();
        end
    endtask

    task automatic test_forwarding();
        logic [31:0] exp_a [4] = '{32'h11, 32'hA0, 32'hB0, 32'hC0};
        logic [31:0] exp_b [4] = '{32'h11, 32'hA0, 32'hB0, 32'h11};
        quiet();
        qb = 32'h11;
        fwd_data = {32'hC0, 32'hB0, 32'hA0};
        for (int s = 0; s < 4; s++) begin
            fwd_sel  = 2'(s);
            in_valid = 1'b1;
            tick();
            n_cmp++; if (out_valid_a !== 1'b1 || b_out_a !== exp_a[s]) begin n_bad++; $display("FAIL fwd_sel%0d: got v=%b %h want v=1 %h", s, out_valid_a, b_out_a, exp_a[s]); end
            n_cmp++; if (b_out_b !== exp_b[s]) begin n_bad++; $display("FAIL fwd2_sel%0d: got %h want %h", s, b_out_b, exp_b[s]); end
        end
        n_cmp++; if (sel_err_b !== 1'b1 || sel_err_a !== 1'b0) begin n_bad++; $display("FAIL sel_err_set: got a=%b b=%b want a=0 b=1", sel_err_a, sel_err_b); end
        quiet();
        tick();
        tick();
        n_cmp++; if (sel_err_b !== 1'b1) begin n_bad++; $display("FAIL sel_err_sticky: got %b want 1", sel_err_b); end
    endtask

    task automatic test_backpressure();
        quiet();
        qb = 32'h5;
        in_valid = 1'b1;
        tick();
        qb = 32'h6;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++; if (in_ready_a !== 1'b0) begin n_bad++; $display("FAIL stall_in_ready%0d: got %b want 0", i, in_ready_a); end
            tick();
            n_cmp++; if (out_valid_a !== 1'b1 || b_out_a !== 32'h5) begin n_bad++; $display("FAIL stall_hold%0d: got v=%b %h want v=1 5", i, out_valid_a, b_out_a); end
        end
        out_ready = 1'b1;
        #1;
        n_cmp++; if (in_ready_a !== 1'b1) begin n_bad++; $display("FAIL release_in_ready: got %b want 1", in_ready_a); end
        tick();
        in_valid = 1'b0;
        n_cmp++; if (out_valid_a !== 1'b1 || b_out_a !== 32'h6) begin n_bad++; $display("FAIL release_next: got v=%b %h want v=1 6", out_valid_a, b_out_a); end
        tick();
        n_cmp++; if (out_valid_a !== 1'b0 || b_out_a !== 32'h6) begin n_bad++; $display("FAIL drain_no_dup: got v=%b %h want v=0 6", out_valid_a, b_out_a); end
    endtask

    task automatic test_flush();
        quiet();
        qb = 32'h7;
        in_valid = 1'b1;
        tick();
        out_ready = 1'b0;
        qb = 32'h8;
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        n_cmp++; if (out_valid_a !== 1'b0 || in_ready_a !== 1'b1) begin n_bad++; $display("FAIL flush_stall: got v=%b rdy=%b want v=0 rdy=1", out_valid_a, in_ready_a); end
        n_cmp++; if (b_out_a !== 32'h7) begin n_bad++; $display("FAIL flush_b_held: got %h want 7", b_out_a); end
        out_ready = 1'b1;
        qb = 32'h9;
        in_valid = 1'b1;
        flush = 1'b1;
        tick();
        quiet();
        n_cmp++; if (out_valid_a !== 1'b0 || b_out_a !== 32'h7) begin n_bad++; $display("FAIL flush_discard: got v=%b %h want v=0 7", out_valid_a, b_out_a); end
    endtask

    task automatic test_reset_mid();
        quiet();
        qb = 32'h33;
        fwd_sel = 2'd3;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        out_ready = 1'b0;
        tick();
        n_cmp++; if (out_valid_a !== 1'b1 || sel_err_b !== 1'b1) begin n_bad++; $display("FAIL pre_reset: got v=%b err=%b want 1/1", out_valid_a, sel_err_b); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++; if (out_valid_a !== 1'b0 || b_out_a !== 32'h0 || sel_err_b !== 1'b0 || out_valid_b !== 1'b0) begin
            n_bad++; $display("FAIL reset_mid: got v=%b b=%h err=%b want 0/0/0", out_valid_a, b_out_a, sel_err_b);
        end
        quiet();
        tick();
    endtask

    task automatic test_random();
        int errs = 0;
        for (int c = 0; c < 400; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 9) == 0);
            qb        = $urandom;
            fwd_data  = {$urandom, $urandom, $urandom};
            fwd_sel   = 2'($urandom);
            imm       = 16'($urandom);
            imm_mode  = 2'($urandom);
            #1;
            n_cmp++;
            if (in_ready_a !== (!m_valid[0] || out_ready) || in_ready_b !== (!m_valid[1] || out_ready)) begin
                n_bad++; errs++;
                if (errs < 10) $display("FAIL rnd_in_ready c%0d: got %b/%b want %b/%b", c, in_ready_a, in_ready_b, !m_valid[0] || out_ready, !m_valid[1] || out_ready);
            end
            tick();
            n_cmp++;
            if (out_valid_a !== m_valid[0] || b_out_a !== m_b[0] || sel_err_a !== m_err[0]) begin
                n_bad++; errs++;
                if (errs < 10) $display("FAIL rnd_a c%0d: got v=%b %h e=%b want v=%b %h e=%b", c, out_valid_a, b_out_a, sel_err_a, m_valid[0], m_b[0], m_err[0]);
            end
            n_cmp++;
            if (out_valid_b !== m_valid[1] || b_out_b !== m_b[1] || sel_err_b !== m_err[1]) begin
                n_bad++; errs++;
                if (errs < 10) $display("FAIL rnd_b c%0d: got v=%b %h e=%b want v=%b %h e=%b", c, out_valid_b, b_out_b, sel_err_b, m_valid[1], m_b[1], m_err[1]);
            end
        end
        quiet();
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            m_valid[i] = 1'b0;
            m_b[i]     = '0;
            m_err[i]   = 1'b0;
        end
        test_reset();
        test_imm_modes();
        test_forwarding();
        test_backpressure();
        test_flush();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
